// File: rtl/adma_as_bresp_dmux.sv
// B-response demultiplexer: remembers which channel owns each AWID in flight and
// routes returning write responses to that channel through a one-entry output buffer.
module adma_as_bresp_dmux #(
   parameter  int DMA_CHN_NUM   = 4,
   parameter  int MST_ID_W      = 5,
   parameter  int MAX_OUTST     = 8,
   localparam int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM),
   localparam int OUTST_CNT_W   = $clog2(MAX_OUTST + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
   input  logic [MST_ID_W-1:0]      atx_awid,
   input  logic                     atx_vld,
   output logic                     atx_rdy,
   input  logic [MST_ID_W-1:0]      m_bid,
   input  logic [1:0]               m_bresp,
   input  logic                     m_bvalid,
   output logic                     m_bready,
   output logic [1:0]               chn_cmpl_resp [0:DMA_CHN_NUM-1],
   output logic                     chn_cmpl_vld  [0:DMA_CHN_NUM-1],
   input  logic                     chn_cmpl_rdy  [0:DMA_CHN_NUM-1],
   output logic [OUTST_CNT_W-1:0]   chn_outst_cnt [0:DMA_CHN_NUM-1],
   output logic                     bid_err
);

   localparam logic [OUTST_CNT_W-1:0] MAX_CNT = OUTST_CNT_W'(MAX_OUTST);

   // All three interfaces use strict valid/ready: a transfer happens on a rising
   // clk edge where valid and ready are both 1; valid never waits on ready, and
   // ready (atx_rdy, m_bready) is a pure function of current state and inputs.

   logic [OUTST_CNT_W-1:0]   cnt    [DMA_CHN_NUM];
   logic [MST_ID_W-1:0]      id_tbl [DMA_CHN_NUM];
   logic                     buf_vld;
   logic [DMA_CHN_NUM_W-1:0] buf_chn;
   logic [1:0]               buf_resp;
   logic                     bid_err_q;

   logic [DMA_CHN_NUM-1:0]   active;
   logic [DMA_CHN_NUM-1:0]   hit;
   logic                     any_hit;
   logic [DMA_CHN_NUM_W-1:0] hit_chn;
   logic                     id_conflict;
   logic                     atx_hs;
   logic                     b_hs;
   logic                     buf_pop;

   // The issue rules keep active IDs unique, so at most one hit bit is ever set.
   always_comb begin
      active      = '0;
      hit         = '0;
      any_hit     = 1'b0;
      hit_chn     = '0;
      id_conflict = 1'b0;
      for (int c = 0; c < DMA_CHN_NUM; c++) begin
         active[c] = (cnt[c] != '0);
         hit[c]    = active[c] && (id_tbl[c] == m_bid);
         if (hit[c]) begin
            any_hit = 1'b1;
            hit_chn = DMA_CHN_NUM_W'(c);
         end
         if (active[c] && (atx_chn_id != DMA_CHN_NUM_W'(c)) && (id_tbl[c] == atx_awid))
            id_conflict = 1'b1;
      end
   end

   always_comb begin
      atx_rdy = (cnt[atx_chn_id] < MAX_CNT) &&
                ((cnt[atx_chn_id] == '0) || (id_tbl[atx_chn_id] == atx_awid)) &&
                !id_conflict;
   end

   assign buf_pop  = buf_vld & chn_cmpl_rdy[buf_chn];
   assign m_bready = ~buf_vld | chn_cmpl_rdy[buf_chn];
   assign atx_hs   = atx_vld & atx_rdy;
   assign b_hs     = m_bvalid & m_bready;

   // An issue and a retiring response on the same channel cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < DMA_CHN_NUM; c++) begin
            cnt[c]    <= '0;
            id_tbl[c] <= '0;
         end
      end else begin
         for (int c = 0; c < DMA_CHN_NUM; c++) begin
            if (atx_hs && (atx_chn_id == DMA_CHN_NUM_W'(c))) begin
               id_tbl[c] <= atx_awid;
               if (!(b_hs && hit[c]))
                  cnt[c] <= cnt[c] + 1'b1;
            end else if (b_hs && hit[c]) begin
               cnt[c] <= cnt[c] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_vld   <= 1'b0;
         buf_chn   <= '0;
         buf_resp  <= '0;
         bid_err_q <= 1'b0;
      end else begin
         bid_err_q <= b_hs & ~any_hit;
         if (b_hs && any_hit) begin
            buf_vld  <= 1'b1;
            buf_chn  <= hit_chn;
            buf_resp <= m_bresp;
         end else if (buf_pop) begin
            buf_vld <= 1'b0;
         end
      end
   end

   always_comb begin
      for (int c = 0; c < DMA_CHN_NUM; c++) begin
         chn_cmpl_vld[c]  = buf_vld && (buf_chn == DMA_CHN_NUM_W'(c));
         chn_cmpl_resp[c] = chn_cmpl_vld[c] ? buf_resp : 2'b00;
         chn_outst_cnt[c] = cnt[c];
      end
   end

   assign bid_err = bid_err_q;

endmodule
